// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings and helpers for the memory-stage load/store unit.
package mem_stage_lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned RSRC_W = 2;

    // Funct3 size/sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // True when the byte offset is not naturally aligned for the access size
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    // Byte offset with the low bits cleared as required by the access size
    function automatic logic [1:0] align_offset(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return off;
            2'b01:   return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// Store lane replication/byte enables and load byte/halfword extract with extension.
module lsu_lane_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic [XLEN-1:0]   load_data
);

    logic [XLEN-1:0] shifted;

    // Lane steering for both directions; funct3[2] selects zero extension
    always_comb begin
        shifted   = rdata >> {offset, 3'b000};
        wdata     = store_data;
        wstrb     = 4'b1111;
        load_data = rdata;
        case (funct3[1:0])
            2'b00: begin
                wdata     = {4{store_data[7:0]}};
                wstrb     = 4'b0001 << offset;
                load_data = funct3[2] ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                wdata     = {2{store_data[15:0]}};
                wstrb     = offset[1] ? 4'b1100 : 4'b0011;
                load_data = funct3[2] ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: begin
                wdata     = store_data;
                wstrb     = 4'b1111;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: drives the valid/ready data bus, stalls upstream, loads MEM/WB.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter bit          MISALIGN_TRAP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   ALUResultM,
    input  logic [XLEN-1:0]   WriteDataM,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        Funct3M,
    input  logic              RegWriteM,
    input  logic [RSRC_W-1:0] ResultSrcM,
    input  logic [REG_W-1:0]  RDM,
    input  logic [XLEN-1:0]   PCPlus4M,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [XLEN-1:0]   req_wdata,
    output logic [STRB_W-1:0] req_wstrb,
    input  logic              rsp_valid,
    input  logic [XLEN-1:0]   rsp_rdata,
    output logic              StallM,
    output logic              misalign_o,
    output logic [XLEN-1:0]   ReadDataW,
    output logic [XLEN-1:0]   ALUResultW,
    output logic [XLEN-1:0]   PCPlus4W,
    output logic [REG_W-1:0]  RDW,
    output logic              RegWriteW,
    output logic [RSRC_W-1:0] ResultSrcW
);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        offset;
    logic              mem_op;
    logic              is_store;
    logic              trap_c;
    logic              req_valid_c;
    logic              stall_c;
    logic [XLEN-1:0]   wdata_c;
    logic [STRB_W-1:0] wstrb_c;
    logic [XLEN-1:0]   load_data_c;

    assign addr     = ALUResultM[ADDR_W-1:0];
    assign offset   = align_offset(Funct3M, addr[1:0]);
    assign mem_op   = MemReadM | MemWriteM;
    // A simultaneous read and write is handled as a store
    assign is_store = MemWriteM;
    assign trap_c   = MISALIGN_TRAP && mem_op && is_misaligned(Funct3M, addr[1:0]);

    lsu_lane_align u_lane_align (
        .funct3     (Funct3M),
        .offset     (offset),
        .store_data (WriteDataM),
        .rdata      (rsp_rdata),
        .wdata      (wdata_c),
        .wstrb      (wstrb_c),
        .load_data  (load_data_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, bus request and stall decode
    always_comb begin
        state_next  = state;
        req_valid_c = 1'b0;
        stall_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_op && !trap_c) begin
                    req_valid_c = 1'b1;
                    if (is_store) begin
                        if (!req_ready) begin
                            stall_c    = 1'b1;
                            state_next = ST_REQ;
                        end
                    end else begin
                        stall_c    = 1'b1;
                        state_next = req_ready ? ST_RESP : ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                req_valid_c = 1'b1;
                if (req_ready) begin
                    if (is_store) begin
                        state_next = ST_IDLE;
                    end else begin
                        stall_c    = 1'b1;
                        state_next = ST_RESP;
                    end
                end else begin
                    stall_c = 1'b1;
                end
            end
            ST_RESP: begin
                stall_c = ~rsp_valid;
                if (rsp_valid) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // MEM/WB register: bubble while stalled, real values on the completing cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ReadDataW  <= '0;
            ALUResultW <= '0;
            PCPlus4W   <= '0;
            RDW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= (state == ST_IDLE) && trap_c;
            if (stall_c) begin
                RegWriteW <= 1'b0;
            end else begin
                ReadDataW  <= (state == ST_RESP) ? load_data_c : '0;
                ALUResultW <= ALUResultM;
                PCPlus4W   <= PCPlus4M;
                RDW        <= RDM;
                RegWriteW  <= RegWriteM && !trap_c;
                ResultSrcW <= ResultSrcM;
            end
        end
    end

    // Combinational bus and stall outputs forced low while reset is asserted
    assign req_valid = req_valid_c & rst;
    assign StallM    = stall_c & rst;
    assign req_we    = is_store & rst;
    assign req_addr  = rst ? {addr[ADDR_W-1:2], 2'b00} : '0;
    assign req_wdata = rst ? wdata_c : '0;
    assign req_wstrb = (rst && is_store) ? wstrb_c : '0;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: vector table plus multi-cycle sequences.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RDM;
    logic [31:0] PCPlus4M;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        StallM;
    logic        misalign_o;
    logic [31:0] ReadDataW;
    logic [31:0] ALUResultW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RDW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;

    int checks;
    int failures;

    mem_stage_lsu #(.ADDR_W(32), .MISALIGN_TRAP(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .RDM        (RDM),
        .PCPlus4M   (PCPlus4M),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .StallM     (StallM),
        .misalign_o (misalign_o),
        .ReadDataW  (ReadDataW),
        .ALUResultW (ALUResultW),
        .PCPlus4W   (PCPlus4W),
        .RDW        (RDW),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  f3;
        logic        rw;
        logic        exp_valid;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic        exp_mis;
        logic        exp_rw;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] wd, input logic rd_en,
                          input logic wr_en, input logic [2:0] f3, input logic rw,
                          input logic [4:0] rd);
        ALUResultM = a;
        WriteDataM = wd;
        MemReadM   = rd_en;
        MemWriteM  = wr_en;
        Funct3M    = f3;
        RegWriteM  = rw;
        RDM        = rd;
        PCPlus4M   = a + 32'd4;
        ResultSrcM = 2'b01;
    endtask

    initial begin
        int stalls;
        int pulses;
        logic done;
        logic [31:0] lb_exp [2];
        logic [2:0]  lb_f3 [2];

        checks   = 0;
        failures = 0;

        //                addr          wdata         rd wr f3      rw  valid strb     exp_wdata     mis erw
        vecs[0] = '{32'h0000_1234, 32'h0,        0, 0, 3'b010, 1, 0, 4'b0000, 32'h0,        0, 1};
        vecs[1] = '{32'h0000_0100, 32'hDEADBEEF, 0, 1, 3'b010, 0, 1, 4'b1111, 32'hDEADBEEF, 0, 0};
        vecs[2] = '{32'h0000_0101, 32'h0,        1, 0, 3'b010, 1, 0, 4'b0000, 32'h0,        1, 0};
        vecs[3] = '{32'h0000_0102, 32'h0000CAFE, 0, 1, 3'b001, 0, 1, 4'b1100, 32'hCAFECAFE, 0, 0};
        vecs[4] = '{32'h0000_0103, 32'h0000BEEF, 0, 1, 3'b001, 0, 0, 4'b0000, 32'h0,        1, 0};
        vecs[5] = '{32'h0000_0101, 32'h12345677, 0, 1, 3'b000, 0, 1, 4'b0010, 32'h77777777, 0, 0};
        vecs[6] = '{32'h0000_0200, 32'h11223344, 1, 1, 3'b010, 0, 1, 4'b1111, 32'h11223344, 0, 0};
        vecs[7] = '{32'h0000_5678, 32'h0,        0, 0, 3'b000, 1, 0, 4'b0000, 32'h0,        0, 1};

        // Reset: outputs low even with a load presented
        rst = 1'b0;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        set_op(32'h100, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd1);
        #3;
        chk("rst req_valid", 32'(req_valid), 32'h0);
        chk("rst StallM", 32'(StallM), 32'h0);
        chk("rst RegWriteW", 32'(RegWriteW), 32'h0);
        chk("rst ALUResultW", ALUResultW, 32'h0);
        chk("rst misalign_o", 32'(misalign_o), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single-cycle operations
        for (int i = 0; i < 8; i++) begin
            set_op(vecs[i].addr, vecs[i].wd, vecs[i].rd_en, vecs[i].wr_en, vecs[i].f3,
                   vecs[i].rw, 5'(i + 1));
            req_ready = 1'b1;
            rsp_valid = 1'b0;
            #1;
            chk($sformatf("v%0d req_valid", i), 32'(req_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d StallM", i), 32'(StallM), 32'h0);
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d req_wstrb", i), 32'(req_wstrb), 32'(vecs[i].exp_strb));
                chk($sformatf("v%0d req_wdata", i), req_wdata, vecs[i].exp_wdata);
                chk($sformatf("v%0d req_we", i), 32'(req_we), 32'h1);
                chk($sformatf("v%0d req_addr", i), req_addr, vecs[i].addr & 32'hFFFF_FFFC);
            end
            step();
            chk($sformatf("v%0d misalign_o", i), 32'(misalign_o), 32'(vecs[i].exp_mis));
            chk($sformatf("v%0d RegWriteW", i), 32'(RegWriteW), 32'(vecs[i].exp_rw));
            chk($sformatf("v%0d ALUResultW", i), ALUResultW, vecs[i].addr);
            chk($sformatf("v%0d PCPlus4W", i), PCPlus4W, vecs[i].addr + 32'd4);
            chk($sformatf("v%0d RDW", i), 32'(RDW), 32'(i + 1));
            chk($sformatf("v%0d ResultSrcW", i), 32'(ResultSrcW), 32'h1);
            chk($sformatf("v%0d ReadDataW", i), ReadDataW, 32'h0);
        end

        // SB to 0x103 held off by req_ready for two cycles
        set_op(32'h103, 32'h0000_00A5, 1'b0, 1'b1, 3'b000, 1'b0, 5'd9);
        req_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("sb c%0d StallM", c), 32'(StallM), 32'h1);
            chk($sformatf("sb c%0d req_valid", c), 32'(req_valid), 32'h1);
            chk($sformatf("sb c%0d req_wstrb", c), 32'(req_wstrb), 32'h8);
            chk($sformatf("sb c%0d req_wdata", c), req_wdata, 32'hA5A5A5A5);
            chk($sformatf("sb c%0d req_addr", c), req_addr, 32'h100);
            step();
            chk($sformatf("sb c%0d RDW bubble", c), 32'(RDW), 32'd8);
        end
        req_ready = 1'b1;
        #1;
        chk("sb accept StallM", 32'(StallM), 32'h0);
        chk("sb accept req_valid", 32'(req_valid), 32'h1);
        chk("sb accept req_wstrb", 32'(req_wstrb), 32'h8);
        step();
        chk("sb done RDW", 32'(RDW), 32'd9);
        set_op(32'h0, 32'h0, 1'b0, 1'b0, 3'b010, 1'b0, 5'd0);
        #1;
        chk("sb idle req_valid", 32'(req_valid), 32'h0);

        // LB and LBU from 0x102 with response one cycle after acceptance
        lb_f3[0]  = 3'b000;
        lb_exp[0] = 32'hFFFF_FF80;
        lb_f3[1]  = 3'b100;
        lb_exp[1] = 32'h0000_0080;
        for (int j = 0; j < 2; j++) begin
            set_op(32'h102, 32'h0, 1'b1, 1'b0, lb_f3[j], 1'b1, 5'(10 + j));
            req_ready = 1'b1;
            rsp_valid = 1'b0;
            #1;
            chk($sformatf("lb%0d req_valid", j), 32'(req_valid), 32'h1);
            chk($sformatf("lb%0d req_wstrb", j), 32'(req_wstrb), 32'h0);
            chk($sformatf("lb%0d issue StallM", j), 32'(StallM), 32'h1);
            step();
            chk($sformatf("lb%0d bubble RegWriteW", j), 32'(RegWriteW), 32'h0);
            rsp_valid = 1'b1;
            rsp_rdata = 32'h1280_3456;
            #1;
            chk($sformatf("lb%0d resp req_valid", j), 32'(req_valid), 32'h0);
            chk($sformatf("lb%0d resp StallM", j), 32'(StallM), 32'h0);
            step();
            chk($sformatf("lb%0d ReadDataW", j), ReadDataW, lb_exp[j]);
            chk($sformatf("lb%0d RegWriteW", j), 32'(RegWriteW), 32'h1);
            chk($sformatf("lb%0d RDW", j), 32'(RDW), 32'(10 + j));
            rsp_valid = 1'b0;
            set_op(32'h0, 32'h0, 1'b0, 1'b0, 3'b010, 1'b0, 5'd0);
            step();
        end

        // LH from 0x102 with the response three cycles after acceptance
        set_op(32'h102, 32'h0, 1'b1, 1'b0, 3'b001, 1'b1, 5'd12);
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0BAD_0BAD;
        stalls = 0;
        pulses = 0;
        done   = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            rsp_valid = (k >= 3);
            if (k >= 3) rsp_rdata = 32'h8001_FFFF;
            #1;
            if (StallM) stalls++;
            else done = 1'b1;
            step();
            if (RegWriteW) pulses++;
            if (done) begin
                chk("lh ReadDataW", ReadDataW, 32'hFFFF_8001);
                chk("lh RDW", 32'(RDW), 32'd12);
                rsp_valid = 1'b0;
                set_op(32'h0, 32'h0, 1'b0, 1'b0, 3'b010, 1'b0, 5'd0);
            end
        end
        chk("lh completes in bound", 32'(done), 32'h1);
        chk("lh stall cycles", 32'(stalls), 32'd3);
        for (int k = 0; k < 2; k++) begin
            step();
            if (RegWriteW) pulses++;
        end
        chk("lh RegWriteW pulses", 32'(pulses), 32'd1);

        // Reset asserted while waiting in RESP, then a late response
        set_op(32'h100, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd14);
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        #1;
        chk("rr issue StallM", 32'(StallM), 32'h1);
        step();
        #1;
        chk("rr resp StallM", 32'(StallM), 32'h1);
        rst = 1'b0;
        #1;
        chk("rr req_valid", 32'(req_valid), 32'h0);
        chk("rr StallM", 32'(StallM), 32'h0);
        chk("rr ALUResultW", ALUResultW, 32'h0);
        chk("rr PCPlus4W", PCPlus4W, 32'h0);
        chk("rr RegWriteW", 32'(RegWriteW), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        set_op(32'h40, 32'h0, 1'b0, 1'b0, 3'b010, 1'b1, 5'd13);
        rsp_valid = 1'b1;
        rsp_rdata = 32'hFFFF_FFFF;
        #1;
        chk("late req_valid", 32'(req_valid), 32'h0);
        chk("late StallM", 32'(StallM), 32'h0);
        step();
        chk("late ReadDataW", ReadDataW, 32'h0);
        chk("late RegWriteW", 32'(RegWriteW), 32'h1);
        chk("late RDW", 32'(RDW), 32'd13);
        rsp_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
